// File: rtl/serial_link_tx_if.sv
// Host-side bundle for serial_link_tx: byte-write strobe and data in, serial frame and status out.
interface serial_link_tx_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             clr_ovr;
  logic             ready;
  logic             serial_out;
  logic             done;
  logic             busy;
  logic             full;
  logic             overrun;

  modport master (
    output load, data_in, clr_ovr,
    input  ready, serial_out, done, busy, full, overrun
  );

  modport slave (
    input  load, data_in, clr_ovr,
    output ready, serial_out, done, busy, full, overrun
  );
endinterface

// File: rtl/serial_link_tx.sv
// Parallel-to-serial frame source for the SAP-II serial input port, with a one-byte holding register.
// Define SERIAL_LINK_TX_GAP_EN to insert one ready=0 cycle between queued frames.
module serial_link_tx #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 nCLR,
  serial_link_tx_if.slave      bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_LINK_TX_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               full_q, full_d;
  logic               ovr_q, ovr_d;
  logic               done_q, done_d;
  logic               drain;
  logic               last_bit;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    drain   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A byte can land in hold on the edge the previous frame ended; send it next.
        if (full_q) begin
          sh_d    = hold_q;
          cnt_d   = '0;
          drain   = 1'b1;
          state_d = SHIFT;
        end else if (bus.load) begin
          sh_d    = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          done_d = 1'b1;
          if (full_q) begin
`ifdef SERIAL_LINK_TX_GAP_EN
            state_d = GAP;
`else
            sh_d  = hold_q;
            cnt_d = '0;
            drain = 1'b1;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef SERIAL_LINK_TX_GAP_EN
      GAP: begin
        sh_d    = hold_q;
        cnt_d   = '0;
        drain   = 1'b1;
        state_d = SHIFT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a load coinciding with a drain refills hold instead of overrunning.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    ovr_d  = ovr_q & ~bus.clr_ovr;
    if (drain) begin
      full_d = bus.load;
      if (bus.load) hold_d = bus.data_in;
    end else if (state_q != IDLE && bus.load) begin
      if (full_q) begin
        ovr_d = 1'b1;
      end else begin
        hold_d = bus.data_in;
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      // NOTE: hold is cleared too so a reset mid-frame cannot resend a stale queued byte.
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready      = (state_q == SHIFT);
  assign bus.serial_out = (state_q == SHIFT) & sh_q[0];
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE) | full_q;
  assign bus.full       = full_q;
  assign bus.overrun    = ovr_q;

endmodule
